// File: rtl/module_width_conv_if.sv
// module_width_conv_if: word-in / slice-out handshake bundle for module_width_conv
interface module_width_conv_if #(parameter int IN_W = 64, parameter int OUT_W = 8, parameter int DEPTH = 4);
  logic strobe_in;
  logic [IN_W-1:0] input_data;
  logic msb_first;
  logic req_data;
  logic ready;
  logic strobe_out;
  logic [OUT_W-1:0] data_out;
  logic data_end;
  logic [$clog2(DEPTH+1)-1:0] fifo_level;
  logic overflow;
  modport master (
    output strobe_in, input_data, msb_first, req_data,
    input ready, strobe_out, data_out, data_end, fifo_level, overflow
  );
  modport slave (
    input strobe_in, input_data, msb_first, req_data,
    output ready, strobe_out, data_out, data_end, fifo_level, overflow
  );
endinterface

// File: rtl/module_width_conv.sv
// module_width_conv: FIFO-buffered wide-to-narrow serializer with per-word slice order
module module_width_conv #(
  parameter int IN_W = 64,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset_n,
  module_width_conv_if.slave bus
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(RATIO);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;
  logic [IN_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic [IN_W-1:0] word;
  logic msb;
  logic [IW-1:0] idx, sel;
  logic [OUT_W-1:0] slice, data_q;
  logic emit, last, pop, push, strobe_q, end_q, overflow_q;
  always_comb begin
    state_nxt = state;
    emit = state == SHIFT && bus.req_data;
    last = idx == IW'(RATIO - 1);
    // Reloading on the last slice keeps back-to-back words gap-free
    pop = (state == IDLE || (emit && last)) && level != '0;
    push = bus.strobe_in && (level != LW'(DEPTH) || pop);
    state_nxt = pop ? SHIFT : (emit && last) ? IDLE : state;
    sel = msb ? IW'(RATIO - 1) - idx : idx;
    slice = OUT_W'(word >> (sel * OUT_W));
  end
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      idx <= '0;
      strobe_q <= 1'b0;
      end_q <= 1'b0;
      data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.input_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        word <= mem[rd_ptr];
        msb <= bus.msb_first;
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level + LW'(push) - LW'(pop);
      idx <= pop ? '0 : emit ? idx + 1'b1 : idx;
      overflow_q <= overflow_q | (bus.strobe_in & ~push);
      strobe_q <= emit;
      end_q <= emit && last;
      if (emit) data_q <= slice;
    end
  assign bus.ready = state == SHIFT;
  assign bus.strobe_out = strobe_q;
  assign bus.data_out = data_q;
  assign bus.data_end = end_q;
  assign bus.fifo_level = level;
  assign bus.overflow = overflow_q;
endmodule

// File: doc/module_width_conv.md
MODULE_WIDTH_CONV -- requirements
Module: module_width_conv

Interface
REQ-001 The module SHALL have parameter IN_W, default 64: input word width in bits.
REQ-002 The module SHALL have parameter OUT_W, default 8: output slice width in bits; IN_W SHALL be an integer multiple of OUT_W, and RATIO = IN_W/OUT_W SHALL be >= 2.
REQ-003 The module SHALL have parameter DEPTH, default 4: input FIFO depth in words; DEPTH SHALL be a power of 2 and >= 2.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The module SHALL have port strobe_in, input, 1 bit: input_data is valid this cycle.
REQ-007 The module SHALL have port input_data, input, IN_W bits: input word.
REQ-008 The module SHALL have port msb_first, input, 1 bit: slice order (1 = most-significant slice first), sampled per word at load.
REQ-009 The module SHALL have port req_data, input, 1 bit: consumer requests one slice.
REQ-010 The module SHALL have port ready, output, 1 bit: a loaded word has slices pending (combinational from state).
REQ-011 The module SHALL have port strobe_out, output, 1 bit: data_out valid (registered).
REQ-012 The module SHALL have port data_out, output, OUT_W bits: output slice (registered).
REQ-013 The module SHALL have port data_end, output, 1 bit: the current strobe_out carries the last slice of a word (registered).
REQ-014 The module SHALL have port fifo_level, output, $clog2(DEPTH+1) bits: number of words held in the FIFO, excluding the shifter.
REQ-015 The module SHALL have port overflow, output, 1 bit: sticky flag meaning at least one input word has been dropped.

Function
REQ-016 The input FIFO SHALL accept a word on an edge with strobe_in=1 when fifo_level<DEPTH, or when fifo_level==DEPTH and a pop occurs on the same edge.
REQ-017 A word offered with strobe_in=1 when the FIFO is full and no pop occurs on that edge SHALL be discarded, SHALL set overflow=1, and SHALL leave the FIFO contents unchanged.
REQ-018 The FIFO read and write pointers SHALL wrap modulo DEPTH, and fifo_level SHALL never exceed DEPTH.
REQ-019 The module SHALL implement a two-state FSM with states IDLE (shifter empty) and SHIFT (shifter loaded).
REQ-020 In IDLE with fifo_level>0, the module SHALL pop the FIFO head into the shifter, latch msb_first, clear the slice index to 0, and go to SHIFT.
REQ-021 In IDLE with fifo_level==0, the module SHALL remain in IDLE.
REQ-022 ready SHALL be 1 if and only if the state is SHIFT.
REQ-023 On an edge with state SHIFT and req_data=1, the module SHALL set strobe_out<=1 and data_out<=slice[idx].
REQ-024 On that same edge, the module SHALL set data_end<=(idx==RATIO-1) and SHALL increment idx.
REQ-025 With the latched msb_first=1, slice[k] SHALL be word[IN_W-1-k*OUT_W -: OUT_W]; with msb_first=0, slice[k] SHALL be word[k*OUT_W +: OUT_W].
REQ-026 On any edge without a slice emission, the module SHALL set strobe_out<=0 and data_end<=0, and data_out SHALL hold its previous value.
REQ-027 On SHIFT with req_data=0, idx and the shifter SHALL hold their values; gaps in req_data SHALL lose no slice.
REQ-028 On emitting the last slice (idx==RATIO-1), the module SHALL pop the next word and stay in SHIFT if fifo_level>0, or go to IDLE otherwise, so that back-to-back words have no strobe_out gap.
REQ-029 Latency SHALL be as follows: a word written at edge k into an empty FIFO with state IDLE causes ready=1 after edge k+1, and the first strobe_out occurs after the first subsequent edge with req_data=1.
REQ-030 req_data=1 while in IDLE SHALL be ignored.
REQ-031 A simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-032 msb_first changes SHALL affect only words loaded after the change.

Reset
REQ-033 On an edge with reset_n=0, the module SHALL enter IDLE and clear idx, the FIFO pointers and fifo_level.
REQ-034 On that edge, the module SHALL set strobe_out=0, data_end=0, data_out=0 and overflow=0, and ready SHALL be 0 from the following cycle.
REQ-035 Reset asserted mid-word SHALL abort the word, and no further strobe_out SHALL occur until a new word is written after reset_n=1.
REQ-036 strobe_in and req_data SHALL be ignored while reset_n=0.

Verification
REQ-037 A bench SHALL cover: with msb_first=1, one write of 64'h0123456789ABCDEF and req_data held 1 -> 8 consecutive strobes with data 01,23,45,67,89,AB,CD,EF, and data_end=1 only with EF.
REQ-038 A bench SHALL cover: the same word with msb_first=0 -> EF,CD,AB,89,67,45,23,01, and data_end=1 only with 01.
REQ-039 A bench SHALL cover: 6 consecutive writes with req_data=0 and DEPTH=4 -> word0 in the shifter, fifo_level=4, word5 dropped and overflow=1; then req_data held 1 -> exactly 40 strobes (words 0-4), 5 data_end pulses, and no gap between words.
REQ-040 A bench SHALL cover: req_data toggling 1,0,1,0 during a word -> slices emitted in order with none skipped or repeated, and strobe_out=1 only on the cycle after each edge with req_data=1.
REQ-041 A bench SHALL cover: reset_n=0 for one cycle after 3 of 8 slices -> next cycle all outputs 0, fifo_level=0 and ready=0, with no strobes until a new write; a new write 64'hFFFF0000FFFF0000 then serializes correctly.
REQ-042 A bench SHALL cover: a write on the same edge as a pop with FIFO full -> the word is accepted, fifo_level stays DEPTH and overflow stays 0.
